pseudo_softmax_normalizer: RTL and testbench
============================================

// Module: pseudo_softmax_normalizer
// PURPOSE
//   Log-domain back end of the pseudo-softmax datapath.
//   - Buffers N integer log2 inputs x_i.
//   - Accepts the floating-point sum S = 2^exp * (1 + mant/2^MANT_WIDTH) from the FLP adder tree.
//   - Converts S to log2 via the Mitchell approximation: L = exp + mant/2^MANT_WIDTH.
//   - Streams y_i = x_i - L for i = 0..N-1 in signed fixed point.
//   Decoding end of the FLP adder chain: takes FLP back to log2 and normalises.
// PARAMETERS
//   N          4  inputs per softmax vector (>=2)
//   IN_WIDTH   8  unsigned width of x_i (IN_WIDTH <= EXP_WIDTH)
//   EXP_WIDTH  9  width of sum exponent
//   MANT_WIDTH 8  fraction bits of sum mantissa (hidden 1 implied) and of y
// PORTS
//   clk        in   1                        clock, rising edge
//   rst        in   1                        synchronous active-high reset
//   in_valid   in   1                        x_data valid
//   in_ready   out  1                        block accepts x_data
//   x_data     in   IN_WIDTH                 log2 input x_i, arrival order = index order
//   sum_valid  in   1                        sum_exp/sum_mant valid
//   sum_ready  out  1                        block accepts sum
//   sum_exp    in   EXP_WIDTH                FLP sum exponent (unsigned)
//   sum_mant   in   MANT_WIDTH               FLP sum mantissa fraction
//   out_valid  out  1                        y valid
//   out_ready  in   1                        downstream accepts y
//   out_data   out  EXP_WIDTH+MANT_WIDTH+1   y_i, signed two's complement Q(EXP_WIDTH+1).MANT_WIDTH
//   out_sat    out  1                        y_i clamped (x_i > L)
//   out_last   out  1                        y_i is index N-1
// BEHAVIOUR
//   - Reset: state=LOAD, count=0, idx=0, sum_got=0.
//     in_ready=1, sum_ready=1, out_valid=0, out_data=0, out_sat=0, out_last=0.
//   - Handshakes: a transfer occurs on any edge where valid&&ready. out_valid may only drop after a transfer.
//     out_data/out_sat/out_last are held stable while out_valid && !out_ready.
//   - LOAD:
//     - in_ready = (count < N).
//     - Each in transfer writes buf[count] and increments count.
//     - On the Nth transfer: go to EMIT if sum_got is set or a sum transfer occurs on that same edge;
//       otherwise go to WAIT_SUM.
//   - WAIT_SUM: in_ready=0. A sum transfer goes to EMIT.
//   - Sum capture:
//     - sum_ready=1 in LOAD and WAIT_SUM, 0 in EMIT.
//     - A transfer latches L = {sum_exp, sum_mant} as unsigned fixed point and sets sum_got.
//     - A repeated sum before EMIT overwrites; latest wins.
//     - A sum may arrive before, during or after the x loading.
//   - EMIT:
//     - in_ready=0.
//     - out_valid=1 from the first cycle in EMIT (one-cycle latency after the entering edge).
//       It stays high until the Nth out transfer.
//     - out_data for idx: d = (buf[idx] << MANT_WIDTH) - L, computed at full signed width.
//       If d > 0 then out_data=0 and out_sat=1; else out_data=d and out_sat=0.
//     - out_last = (idx == N-1).
//     - Each out transfer increments idx and registers the next y.
//     - On the Nth transfer: out_valid=0, count=0, idx=0, sum_got=0, go to LOAD.
//       in_ready=1 on the next cycle.
//   - Widths: x is zero-extended. L <= 2^(EXP_WIDTH+MANT_WIDTH)-1, so y never overflows
//     EXP_WIDTH+MANT_WIDTH+1 bits.
//   - rst asserted in any state (including mid-EMIT with out_valid high) restores reset values on that edge.
//     Buffered x values and sum are discarded.
// TESTING
//   1 N=4. x=3,3,3,3; sum exp=5 mant=0 after loading
//     -> out_data=-512 (-2.0) x4, out_sat=0, out_last only on the 4th.
//   2 Sum sent first (exp=6, mant=128 => L=1664), then x=5,4,3,2
//     -> y=-384,-640,-896,-1152. Enters EMIT without a WAIT_SUM cycle.
//   3 x=10,0,0,0; L=1280 -> y0=0 with out_sat=1; y1..3=-1280 with out_sat=0.
//   4 Backpressure: out_ready toggles 1,0,0,1,... -> each y stays stable while stalled;
//     exactly 4 transfers; in_ready=0 until after the last.
//   5 Sum presented twice in LOAD (exp=5 then exp=7, mant=0), x=7,7,7,7
//     -> y=0 x4 (L=1792, latest wins), out_sat=0.
//   6 rst pulsed after the 2nd output transfer -> next cycle out_valid=0, in_ready=1, sum_ready=1.
//     A fresh vector of scenario 1 then yields all 4 outputs correctly.

Source files
------------

// File: rtl/pseudo_softmax_normalizer_if.sv
// Handshake bundle for the pseudo-softmax normaliser: x stream in, FLP sum in, y stream out.
// The master side produces x and sum and consumes y; the normaliser sits on the slave side.
interface pseudo_softmax_normalizer_if #(
    parameter int IN_WIDTH   = 8,
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8
);
    logic                            inValid;
    logic                            inReady;
    logic [IN_WIDTH-1:0]             xData;
    logic                            sumValid;
    logic                            sumReady;
    logic [EXP_WIDTH-1:0]            sumExp;
    logic [MANT_WIDTH-1:0]           sumMant;
    logic                            outValid;
    logic                            outReady;
    logic [EXP_WIDTH+MANT_WIDTH:0]   outData;
    logic                            outSat;
    logic                            outLast;

    modport master (
        output inValid, xData, sumValid, sumExp, sumMant, outReady,
        input  inReady, sumReady, outValid, outData, outSat, outLast
    );

    modport slave (
        input  inValid, xData, sumValid, sumExp, sumMant, outReady,
        output inReady, sumReady, outValid, outData, outSat, outLast
    );
endinterface

// File: rtl/pseudo_softmax_normalizer.sv
// Log-domain back end of the pseudo-softmax: buffers N log2 inputs, turns the FLP sum into
// log2 with the Mitchell approximation and streams y_i = x_i - L, clamped at zero.
module pseudo_softmax_normalizer #(
    parameter int N          = 4,
    parameter int IN_WIDTH   = 8,
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8
) (
    input logic                        clk,
    input logic                        rst,
    pseudo_softmax_normalizer_if.slave io_bus
);
    localparam int LW = EXP_WIDTH + MANT_WIDTH;
    localparam int DW = LW + 1;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {LOAD, WAIT_SUM, EMIT} stateType;

    stateType              r_state;
    stateType              w_stateNext;
    logic [IN_WIDTH-1:0]   r_buf [N];
    logic [CW-1:0]         r_count;
    logic [IW-1:0]         r_idx;
    logic [LW-1:0]         r_L;
    logic                  r_sumGot;
    logic                  r_outValid;
    logic [DW-1:0]         r_outData;
    logic                  r_outSat;
    logic                  r_outLast;

    logic                  w_inReady;
    logic                  w_sumReady;
    logic                  w_inFire;
    logic                  w_sumFire;
    logic                  w_outFire;
    logic                  w_lastIn;
    logic                  w_enterEmit;
    logic [IW-1:0]         w_wrIdx;
    logic [IW-1:0]         w_nextIdx;
    logic [LW-1:0]         w_Lnext;
    logic [IN_WIDTH-1:0]   w_selX;
    logic [DW-1:0]         w_xExt;
    logic [DW-1:0]         w_lExt;
    logic [DW-1:0]         w_diff;
    logic                  w_ySat;
    logic [DW-1:0]         w_yData;

    assign w_inReady  = (r_state == LOAD) && (r_count < CW'(N));
    assign w_sumReady = (r_state != EMIT);
    assign w_inFire   = io_bus.inValid && w_inReady;
    assign w_sumFire  = io_bus.sumValid && w_sumReady;
    assign w_outFire  = r_outValid && io_bus.outReady;
    assign w_lastIn   = (r_count == CW'(N - 1));
    assign w_wrIdx    = r_count[IW-1:0];
    assign w_nextIdx  = r_idx + IW'(1);

    // Sequencing: load x (sum may land any time), wait for a missing sum, then stream y
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            LOAD: begin
                if (w_inFire && w_lastIn) begin
                    w_stateNext = (r_sumGot || w_sumFire) ? EMIT : WAIT_SUM;
                end
            end
            WAIT_SUM: begin
                if (w_sumFire) begin
                    w_stateNext = EMIT;
                end
            end
            EMIT: begin
                if (w_outFire && r_outLast) begin
                    w_stateNext = LOAD;
                end
            end
            default: w_stateNext = LOAD;
        endcase
    end

    // The first y is formed on the entering edge, possibly with a sum that lands on that same edge
    assign w_enterEmit = (r_state != EMIT) && (w_stateNext == EMIT);
    assign w_Lnext     = w_sumFire ? {io_bus.sumExp, io_bus.sumMant} : r_L;
    assign w_selX      = w_enterEmit ? r_buf[0] : r_buf[w_nextIdx];
    assign w_xExt      = {{(DW - IN_WIDTH - MANT_WIDTH){1'b0}}, w_selX, {MANT_WIDTH{1'b0}}};
    assign w_lExt      = {1'b0, w_Lnext};
    assign w_diff      = w_xExt - w_lExt;
    assign w_ySat      = !w_diff[DW-1] && (w_diff != '0);
    assign w_yData     = w_ySat ? '0 : w_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_count    <= '0;
            r_idx      <= '0;
            r_L        <= '0;
            r_sumGot   <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSat   <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_inFire) begin
                r_buf[w_wrIdx] <= io_bus.xData;
                r_count        <= r_count + CW'(1);
            end
            if (w_sumFire) begin
                r_L      <= {io_bus.sumExp, io_bus.sumMant};
                r_sumGot <= 1'b1;
            end
            if (w_enterEmit) begin
                r_outValid <= 1'b1;
                r_idx      <= '0;
                r_outData  <= w_yData;
                r_outSat   <= w_ySat;
                r_outLast  <= 1'b0;
            end else if (w_outFire) begin
                if (r_outLast) begin
                    r_outValid <= 1'b0;
                    r_count    <= '0;
                    r_idx      <= '0;
                    r_sumGot   <= 1'b0;
                end else begin
                    r_idx     <= w_nextIdx;
                    r_outData <= w_yData;
                    r_outSat  <= w_ySat;
                    r_outLast <= (w_nextIdx == IW'(N - 1));
                end
            end
        end
    end

    assign io_bus.inReady  = w_inReady;
    assign io_bus.sumReady = w_sumReady;
    assign io_bus.outValid = r_outValid;
    assign io_bus.outData  = r_outData;
    assign io_bus.outSat   = r_outSat;
    assign io_bus.outLast  = r_outLast;
endmodule

// File: tb/tb_pseudo_softmax_normalizer.sv
// Directed bench for pseudo_softmax_normalizer: N=4, 8-bit x, 9-bit exponent, 8-bit mantissa.
// Stimulus and handshakes change on the falling edge; outputs are sampled there too.
module tb_pseudo_softmax_normalizer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pseudo_softmax_normalizer_if #(.IN_WIDTH(8), .EXP_WIDTH(9), .MANT_WIDTH(8)) bus ();

    pseudo_softmax_normalizer #(.N(4), .IN_WIDTH(8), .EXP_WIDTH(9), .MANT_WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int     errors = 0;
    int     checks = 0;
    integer gotData [4];
    logic   gotSat  [4];
    logic   gotLast [4];
    int     gotCount;
    int     stallChanges;
    int     inReadyDuringEmit;
    logic   postValid;
    logic   postInReady;

    task automatic sendX(input logic [7:0] v);
        int t = 0;
        bus.inValid = 1'b1;
        bus.xData   = v;
        while (!bus.inReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            $display("[TB] FAIL sendX handshake: inReady=%0b required=1", bus.inReady);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.inValid = 1'b0;
    endtask

    task automatic sendSum(input logic [8:0] e, input logic [7:0] m);
        int t = 0;
        bus.sumValid = 1'b1;
        bus.sumExp   = e;
        bus.sumMant  = m;
        while (!bus.sumReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            $display("[TB] FAIL sendSum handshake: sumReady=%0b required=1", bus.sumReady);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.sumValid = 1'b0;
    endtask

    task automatic loadVector(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        sendX(a);
        sendX(b);
        sendX(c);
        sendX(d);
    endtask

    // Drains up to maxXfers outputs with a repeating ready pattern, recording what was seen
    task automatic collectOutputs(input logic [3:0] pattern, input int maxXfers);
        int          cyc = 0;
        logic        havePrev;
        logic [17:0] prevData;
        logic        prevSat;
        logic        prevLast;
        havePrev = 1'b0;
        prevData = '0;
        prevSat  = 1'b0;
        prevLast = 1'b0;
        gotCount = 0;
        stallChanges = 0;
        inReadyDuringEmit = 0;
        for (int i = 0; i < 4; i++) begin
            gotData[i] = 'x;
            gotSat[i]  = 1'bx;
            gotLast[i] = 1'bx;
        end
        while (gotCount < maxXfers && cyc < 100) begin
            if (bus.outValid) begin
                if (havePrev && ({bus.outData, bus.outSat, bus.outLast} !== {prevData, prevSat, prevLast}))
                    stallChanges++;
                if (bus.inReady)
                    inReadyDuringEmit++;
                bus.outReady = pattern[2'(cyc % 4)];
                if (bus.outReady) begin
                    gotData[gotCount] = 32'($signed(bus.outData));
                    gotSat[gotCount]  = bus.outSat;
                    gotLast[gotCount] = bus.outLast;
                    gotCount++;
                    havePrev = 1'b0;
                end else begin
                    havePrev = 1'b1;
                    prevData = bus.outData;
                    prevSat  = bus.outSat;
                    prevLast = bus.outLast;
                end
            end else begin
                bus.outReady = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.outReady = 1'b0;
        postValid    = bus.outValid;
        postInReady  = bus.inReady;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        bus.inValid  = 1'b0;
        bus.xData    = '0;
        bus.sumValid = 1'b0;
        bus.sumExp   = '0;
        bus.sumMant  = '0;
        bus.outReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.inReady !== 1'b1) begin $display("[TB] FAIL reset inReady: got %0b want 1", bus.inReady); errors++; end
        checks++; if (bus.sumReady !== 1'b1) begin $display("[TB] FAIL reset sumReady: got %0b want 1", bus.sumReady); errors++; end
        checks++; if (bus.outValid !== 1'b0) begin $display("[TB] FAIL reset outValid: got %0b want 0", bus.outValid); errors++; end
        checks++; if (bus.outData !== 18'd0) begin $display("[TB] FAIL reset outData: got %0d want 0", bus.outData); errors++; end
        checks++; if (bus.outSat !== 1'b0) begin $display("[TB] FAIL reset outSat: got %0b want 0", bus.outSat); errors++; end
        checks++; if (bus.outLast !== 1'b0) begin $display("[TB] FAIL reset outLast: got %0b want 0", bus.outLast); errors++; end
    endtask

    task automatic test_sum_after_load;
        integer expData [4] = '{-512, -512, -512, -512};
        loadVector(8'd3, 8'd3, 8'd3, 8'd3);
        checks++; if (bus.outValid !== 1'b0) begin $display("[TB] FAIL s1 waitsum outValid: got %0b want 0", bus.outValid); errors++; end
        checks++; if (bus.inReady !== 1'b0) begin $display("[TB] FAIL s1 waitsum inReady: got %0b want 0", bus.inReady); errors++; end
        checks++; if (bus.sumReady !== 1'b1) begin $display("[TB] FAIL s1 waitsum sumReady: got %0b want 1", bus.sumReady); errors++; end
        sendSum(9'd5, 8'd0);
        checks++; if (bus.outValid !== 1'b1) begin $display("[TB] FAIL s1 emit latency outValid: got %0b want 1", bus.outValid); errors++; end
        collectOutputs(4'b1111, 4);
        checks++; if (gotCount !== 4) begin $display("[TB] FAIL s1 count: got %0d want 4", gotCount); errors++; end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== expData[i]) begin $display("[TB] FAIL s1 y%0d data: got %0d want %0d", i, gotData[i], expData[i]); errors++; end
            checks++; if (gotSat[i] !== 1'b0) begin $display("[TB] FAIL s1 y%0d sat: got %0b want 0", i, gotSat[i]); errors++; end
            checks++; if (gotLast[i] !== (i == 3)) begin $display("[TB] FAIL s1 y%0d last: got %0b want %0b", i, gotLast[i], (i == 3)); errors++; end
        end
        checks++; if (postValid !== 1'b0) begin $display("[TB] FAIL s1 post outValid: got %0b want 0", postValid); errors++; end
        checks++; if (postInReady !== 1'b1) begin $display("[TB] FAIL s1 post inReady: got %0b want 1", postInReady); errors++; end
    endtask

    task automatic test_sum_first;
        integer expData [4] = '{-384, -640, -896, -1152};
        sendSum(9'd6, 8'd128);
        loadVector(8'd5, 8'd4, 8'd3, 8'd2);
        checks++; if (bus.outValid !== 1'b1) begin $display("[TB] FAIL s2 direct emit outValid: got %0b want 1", bus.outValid); errors++; end
        collectOutputs(4'b1111, 4);
        checks++; if (gotCount !== 4) begin $display("[TB] FAIL s2 count: got %0d want 4", gotCount); errors++; end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== expData[i]) begin $display("[TB] FAIL s2 y%0d data: got %0d want %0d", i, gotData[i], expData[i]); errors++; end
            checks++; if (gotSat[i] !== 1'b0) begin $display("[TB] FAIL s2 y%0d sat: got %0b want 0", i, gotSat[i]); errors++; end
        end
    endtask

    task automatic test_saturation;
        integer expData [4] = '{0, -1280, -1280, -1280};
        logic   expSat  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        sendX(8'd10);
        sendX(8'd0);
        sendSum(9'd5, 8'd0);
        sendX(8'd0);
        sendX(8'd0);
        checks++; if (bus.outValid !== 1'b1) begin $display("[TB] FAIL s3 emit outValid: got %0b want 1", bus.outValid); errors++; end
        collectOutputs(4'b1111, 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== expData[i]) begin $display("[TB] FAIL s3 y%0d data: got %0d want %0d", i, gotData[i], expData[i]); errors++; end
            checks++; if (gotSat[i] !== expSat[i]) begin $display("[TB] FAIL s3 y%0d sat: got %0b want %0b", i, gotSat[i], expSat[i]); errors++; end
        end
    endtask

    task automatic test_backpressure;
        // L = 768: y hits exactly zero (not clamped) and a positive difference (clamped)
        integer expData [4] = '{-512, -256, 0, 0};
        logic   expSat  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        sendSum(9'd3, 8'd0);
        loadVector(8'd1, 8'd2, 8'd3, 8'd4);
        collectOutputs(4'b1001, 4);
        checks++; if (gotCount !== 4) begin $display("[TB] FAIL s4 count: got %0d want 4", gotCount); errors++; end
        checks++; if (stallChanges !== 0) begin $display("[TB] FAIL s4 stall stability: got %0d changes want 0", stallChanges); errors++; end
        checks++; if (inReadyDuringEmit !== 0) begin $display("[TB] FAIL s4 inReady during emit: got %0d cycles want 0", inReadyDuringEmit); errors++; end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== expData[i]) begin $display("[TB] FAIL s4 y%0d data: got %0d want %0d", i, gotData[i], expData[i]); errors++; end
            checks++; if (gotSat[i] !== expSat[i]) begin $display("[TB] FAIL s4 y%0d sat: got %0b want %0b", i, gotSat[i], expSat[i]); errors++; end
            checks++; if (gotLast[i] !== (i == 3)) begin $display("[TB] FAIL s4 y%0d last: got %0b want %0b", i, gotLast[i], (i == 3)); errors++; end
        end
        checks++; if (postValid !== 1'b0) begin $display("[TB] FAIL s4 post outValid: got %0b want 0", postValid); errors++; end
        checks++; if (postInReady !== 1'b1) begin $display("[TB] FAIL s4 post inReady: got %0b want 1", postInReady); errors++; end
    endtask

    task automatic test_latest_sum;
        sendSum(9'd5, 8'd0);
        sendSum(9'd7, 8'd0);
        loadVector(8'd7, 8'd7, 8'd7, 8'd7);
        collectOutputs(4'b1111, 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== 0) begin $display("[TB] FAIL s5 y%0d data: got %0d want 0", i, gotData[i]); errors++; end
            checks++; if (gotSat[i] !== 1'b0) begin $display("[TB] FAIL s5 y%0d sat: got %0b want 0", i, gotSat[i]); errors++; end
        end
    endtask

    task automatic test_same_edge;
        // Last x and the sum arrive together; L = 2*256+64 = 576, y = 512-576 = -64
        sendX(8'd2);
        sendX(8'd2);
        sendX(8'd2);
        bus.inValid  = 1'b1;
        bus.xData    = 8'd2;
        bus.sumValid = 1'b1;
        bus.sumExp   = 9'd2;
        bus.sumMant  = 8'd64;
        @(posedge clk);
        @(negedge clk);
        bus.inValid  = 1'b0;
        bus.sumValid = 1'b0;
        checks++; if (bus.outValid !== 1'b1) begin $display("[TB] FAIL same-edge outValid: got %0b want 1", bus.outValid); errors++; end
        collectOutputs(4'b1111, 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== -64) begin $display("[TB] FAIL same-edge y%0d data: got %0d want -64", i, gotData[i]); errors++; end
        end
    endtask

    task automatic test_reset_mid_emit;
        loadVector(8'd3, 8'd3, 8'd3, 8'd3);
        sendSum(9'd5, 8'd0);
        collectOutputs(4'b1111, 2);
        checks++; if (gotCount !== 2) begin $display("[TB] FAIL s6 partial count: got %0d want 2", gotCount); errors++; end
        checks++; if (gotData[1] !== -512) begin $display("[TB] FAIL s6 partial y1: got %0d want -512", gotData[1]); errors++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.outValid !== 1'b0) begin $display("[TB] FAIL s6 rst outValid: got %0b want 0", bus.outValid); errors++; end
        checks++; if (bus.inReady !== 1'b1) begin $display("[TB] FAIL s6 rst inReady: got %0b want 1", bus.inReady); errors++; end
        checks++; if (bus.sumReady !== 1'b1) begin $display("[TB] FAIL s6 rst sumReady: got %0b want 1", bus.sumReady); errors++; end
        checks++; if (bus.outData !== 18'd0) begin $display("[TB] FAIL s6 rst outData: got %0d want 0", bus.outData); errors++; end
        loadVector(8'd3, 8'd3, 8'd3, 8'd3);
        checks++; if (bus.outValid !== 1'b0) begin $display("[TB] FAIL s6 sum discarded outValid: got %0b want 0", bus.outValid); errors++; end
        sendSum(9'd5, 8'd0);
        collectOutputs(4'b1111, 4);
        checks++; if (gotCount !== 4) begin $display("[TB] FAIL s6 fresh count: got %0d want 4", gotCount); errors++; end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gotData[i] !== -512) begin $display("[TB] FAIL s6 fresh y%0d data: got %0d want -512", i, gotData[i]); errors++; end
            checks++; if (gotLast[i] !== (i == 3)) begin $display("[TB] FAIL s6 fresh y%0d last: got %0b want %0b", i, gotLast[i], (i == 3)); errors++; end
        end
    endtask

    initial begin
        test_reset();
        test_sum_after_load();
        test_sum_first();
        test_saturation();
        test_backpressure();
        test_latest_sum();
        test_same_edge();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
